// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side bridge: SRAM-like fetch port (req/addr_ok/data_ok) to AXI4 read-only master.
// Latency: accept in cycle N drives arvalid in N+1; read data returned to IF one cycle after each R beat.
// Backpressure: addr_ok held low while an AR is pending or MAX_OUTSTANDING reads are unreturned; rready always high.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   inst_sram_*           - fetch-side request/response port (writes are never accepted)
//   ar*                   - AXI read address channel (single-beat, incrementing, fixed ID)
//   r*                    - AXI read data channel (in-order, rid/rresp ignored)
module inst_axi_rd_bridge #(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID_VAL        = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [0:0] AR_IDLE = 1'b0;
  localparam logic [0:0] AR_BUSY = 1'b1;

  // Outstanding limit is at most 3, so a 2-bit counter is sufficient.
  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  logic [0:0]  ar_state;
  logic [1:0]  cnt;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic        data_ok_q;
  logic [31:0] rdata_reg;

  logic accept;
  logic r_fire;

  // Only one request is taken per AR transaction, so the idle state gates acceptance.
  assign accept = !reset && (ar_state == AR_IDLE) && inst_sram_req && !inst_sram_wr && (cnt < MAX_CNT);

  // A beat with nothing outstanding is consumed silently (no data_ok, no count change).
  assign r_fire = rvalid && rready && rlast && (cnt != 2'd0);

  assign inst_sram_addr_ok = accept;
  assign inst_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_reg;

  assign arid    = ARID_VAL;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (ar_state == AR_BUSY);
  assign rready  = !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state <= AR_IDLE;
      addr_q   <= 32'd0;
      size_q   <= 2'd0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (accept) begin
            ar_state <= AR_BUSY;
            addr_q   <= inst_sram_addr;
            size_q   <= inst_sram_size;
          end
        end
        AR_BUSY: begin
          if (arready) ar_state <= AR_IDLE;
        end
        default: ar_state <= AR_IDLE;
      endcase
    end
  end

  // Increment and decrement in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
    end else if (accept && !r_fire) begin
      cnt <= cnt + 2'd1;
    end else if (r_fire && !accept) begin
      cnt <= cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_reg <= 32'd0;
    end else begin
      data_ok_q <= r_fire;
      if (r_fire) rdata_reg <= rdata;
    end
  end

  // Write-side inputs and R-channel metadata are deliberately unused.
  logic unused_ok;
  assign unused_ok = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp};

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
module tb_inst_axi_rd_bridge;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_req = 1'b0;
  logic        inst_sram_wr = 1'b0;
  logic [1:0]  inst_sram_size = 2'd0;
  logic [3:0]  inst_sram_wstrb = 4'd0;
  logic [31:0] inst_sram_addr = 32'd0;
  logic [31:0] inst_sram_wdata = 32'd0;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rlast = 1'b1;
  logic        rvalid = 1'b0;
  logic        rready;

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(MAX), .ARID_VAL(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int aok_pulses = 0;

  // Reference model: a pending AR slot plus a queue of accepted-but-unreturned addresses.
  logic        m_busy = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] inflight[$];
  logic        m_dok = 1'b0;
  logic [31:0] m_rreg = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check the model at negedge, then advance the model.
  task automatic step(input logic rst, input logic rq, input logic w, input logic [31:0] a,
                      input logic [1:0] sz, input logic ar_rdy, input logic rv, input logic [31:0] rd);
    logic e_aok;
    @(posedge clk);
    #1;
    reset = rst; inst_sram_req = rq; inst_sram_wr = w; inst_sram_addr = a; inst_sram_size = sz;
    inst_sram_wstrb = 4'($urandom); inst_sram_wdata = $urandom;
    arready = ar_rdy; rvalid = rv; rdata = rd; rlast = 1'b1;
    rid = 4'($urandom); rresp = 2'($urandom);
    @(negedge clk);
    e_aok = !rst && rq && !w && !m_busy && (inflight.size() < MAX);
    chk("addr_ok", {31'd0, inst_sram_addr_ok}, {31'd0, e_aok});
    chk("arvalid", {31'd0, arvalid}, {31'd0, m_busy});
    chk("araddr", araddr, m_addr);
    chk("arsize", {29'd0, arsize}, {30'd0, m_size});
    chk("data_ok", {31'd0, inst_sram_data_ok}, {31'd0, m_dok});
    chk("rdata", inst_sram_rdata, m_rreg);
    chk("rready", {31'd0, rready}, {31'd0, !rst});
    if (inst_sram_addr_ok) aok_pulses++;
    if (rst) begin
      m_busy = 0; m_addr = 0; m_size = 0; inflight.delete(); m_dok = 0; m_rreg = 0;
    end else begin
      m_dok = rv && (inflight.size() > 0);
      if (m_dok) begin
        m_rreg = rd;
        void'(inflight.pop_front());
      end
      if (e_aok) begin
        m_busy = 1; m_addr = a; m_size = sz;
        inflight.push_back(a);
      end else if (m_busy && ar_rdy) begin
        m_busy = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 32'd0, 2'd0, 0, 0, 32'd0);
  endtask

  typedef struct {
    logic        req, wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        arready, rvalid;
    logic [31:0] rdata;
    logic        e_aok, e_arv, e_dok;
    logic [31:0] e_araddr, e_rdata;
  } vec_t;

  vec_t tv[11];

  initial begin
    // Single fetch, then a write request and a spurious R beat.
    tv[0]  = '{1, 0, 32'h1c000000, 2, 0, 0, 0,            1, 0, 0, 32'h0,        32'h0};
    tv[1]  = '{0, 0, 0,            0, 0, 0, 0,            0, 1, 0, 32'h1c000000, 32'h0};
    tv[2]  = '{0, 0, 0,            0, 0, 0, 0,            0, 1, 0, 32'h1c000000, 32'h0};
    tv[3]  = '{0, 0, 0,            0, 1, 0, 0,            0, 1, 0, 32'h1c000000, 32'h0};
    tv[4]  = '{0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 32'h1c000000, 32'h0};
    tv[5]  = '{0, 0, 0,            0, 0, 1, 32'h02800000, 0, 0, 0, 32'h1c000000, 32'h0};
    tv[6]  = '{0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 32'h1c000000, 32'h02800000};
    tv[7]  = '{0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 32'h1c000000, 32'h02800000};
    tv[8]  = '{1, 1, 32'h1c000040, 2, 1, 0, 0,            0, 0, 0, 32'h1c000000, 32'h02800000};
    tv[9]  = '{1, 1, 32'h1c000040, 2, 1, 1, 32'hdeadbeef, 0, 0, 0, 32'h1c000000, 32'h02800000};
    tv[10] = '{0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 32'h1c000000, 32'h02800000};

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'h1000, 2, 1, 1, 32'h1234);
    chk("reset_cnt", {30'd0, dut.cnt}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      step(0, tv[i].req, tv[i].wr, tv[i].addr, tv[i].size, tv[i].arready, tv[i].rvalid, tv[i].rdata);
      chk($sformatf("tv%0d.addr_ok", i), {31'd0, inst_sram_addr_ok}, {31'd0, tv[i].e_aok});
      chk($sformatf("tv%0d.arvalid", i), {31'd0, arvalid}, {31'd0, tv[i].e_arv});
      chk($sformatf("tv%0d.araddr", i), araddr, tv[i].e_araddr);
      chk($sformatf("tv%0d.data_ok", i), {31'd0, inst_sram_data_ok}, {31'd0, tv[i].e_dok});
      chk($sformatf("tv%0d.rdata", i), inst_sram_rdata, tv[i].e_rdata);
    end
    chk("spurious_cnt", {30'd0, dut.cnt}, 32'd0);

    // Outstanding limit: hold req with arready=1 and no R beats.
    aok_pulses = 0;
    for (int k = 0; k < 8; k++) step(0, 1, 0, 32'h2000 + 32'(4 * k), 2, 1, 0, 0);
    chk("limit_pulses", aok_pulses, 32'd2);
    step(0, 1, 0, 32'h3000, 2, 1, 1, 32'haaaa0001);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 32'h3100, 2, 1, 0, 0);
    chk("limit_after_beat", aok_pulses, 32'd3);
    // Drain both outstanding reads.
    step(0, 0, 0, 0, 0, 1, 1, 32'hbbbb0002);
    step(0, 0, 0, 0, 0, 1, 1, 32'hbbbb0003);
    idle(2);
    chk("drain_cnt", {30'd0, dut.cnt}, 32'd0);

    // Simultaneous accept and R beat: count unchanged, data_ok and arvalid next cycle.
    step(0, 1, 0, 32'h4000, 2, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 32'h4004, 2, 0, 1, 32'hcafe0001);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("simul_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    chk("simul_arvalid", {31'd0, arvalid}, 32'd1);
    chk("simul_cnt", {30'd0, dut.cnt}, 32'd1);

    // Stalled AR: arready low for 5 cycles while req stays asserted.
    aok_pulses = 0;
    for (int k = 0; k < 5; k++) step(0, 1, 0, 32'h5000, 1, 0, 0, 0);
    chk("stall_pulses", aok_pulses, 32'd0);
    chk("stall_araddr", araddr, 32'h4004);
    step(0, 0, 0, 0, 0, 1, 1, 32'hcafe0002);
    step(0, 0, 0, 0, 0, 0, 1, 32'hcafe0003);
    idle(2);

    // Reset while AR_BUSY with one read in flight, then a fresh fetch.
    step(0, 1, 0, 32'h6000, 2, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_cnt", {30'd0, dut.cnt}, 32'd0);
    chk("rst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    step(0, 1, 0, 32'h7000, 2, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h7777aaaa);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fresh_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    chk("fresh_rdata", inst_sram_rdata, 32'h7777aaaa);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
           {$urandom_range(0, 32'h0fffffff), 2'b00} & 32'h3ffffffc,
           2'($urandom_range(0, 2)),
           ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
           $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
